// File: rtl/imm_gen_pkg.sv
// Shared types for the immediate generator: ext_op encodings, result record, XLEN constants.
// Optional feature macro: IMM_GEN_CSR_ZIMM_EN (see imm_ext_core).
package imm_gen_pkg;

    localparam int XLEN_32   = 32;
    localparam int XLEN_64   = 64;
    localparam int MAX_XLEN  = XLEN_64;
    localparam int MAX_TAG_W = 64;

    typedef enum logic [2:0] {
        EXT_NONE     = 3'b000,
        EXT_S        = 3'b001,
        EXT_I        = 3'b010,
        EXT_I_SHAMT  = 3'b011,
        EXT_B        = 3'b100,
        EXT_U        = 3'b101,
        EXT_J        = 3'b110,
        EXT_CSR_ZIMM = 3'b111
    } ext_op_e;

    // Widest-case record of one result; narrower configurations zero-fill the upper bits.
    typedef struct packed {
        logic [MAX_XLEN-1:0]  imm;
        logic [MAX_TAG_W-1:0] tag;
        logic                 illegal;
    } imm_result_t;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == XLEN_32) || (xlen == XLEN_64);
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Bundle of the upstream and downstream handshake buses of imm_gen_pipe.
// Handshake: a beat moves when valid && ready on the same rising edge; valid never waits on ready.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [2:0]       ext_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  immout;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    modport master (
        output in_valid, instr, ext_op, in_tag, out_ready,
        input  in_ready, out_valid, immout, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, instr, ext_op, in_tag, out_ready,
        output in_ready, out_valid, immout, out_tag, out_illegal
    );
endinterface

// File: rtl/imm_ext_core.sv
// Combinational field extraction and extension of a RISC-V immediate.
// IMM_GEN_CSR_ZIMM_EN defined: CSR_ZIMM is supported; otherwise it is flagged illegal.
module imm_ext_core
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      ext_op,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    // Every case builds a 32-bit value whose bit 31 is the correct extension bit,
    // so a single signed widening covers both the XLEN=32 and XLEN=64 builds.
    logic [31:0] raw;
    logic        unused_opcode;

    assign unused_opcode = ^instr[6:0];

    always_comb begin
        raw     = '0;
        illegal = 1'b0;
        case (ext_op_e'(ext_op))
            EXT_I:       raw = {{20{instr[31]}}, instr[31:20]};
            EXT_S:       raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            EXT_B:       raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            EXT_U:       raw = {instr[31:12], 12'b0};
            EXT_J:       raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            EXT_I_SHAMT: raw = (XLEN == XLEN_64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
`ifdef IMM_GEN_CSR_ZIMM_EN
            EXT_CSR_ZIMM: raw = {27'b0, instr[19:15]};
`else
            EXT_CSR_ZIMM: illegal = 1'b1;
`endif
            default:     raw = '0;
        endcase
    end

    assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a registered output stage and a one-entry skid buffer.
// Macro IMM_GEN_CSR_ZIMM_EN enables the CSR_ZIMM immediate type.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    imm_gen_pipe_if.slave bus
);

    logic [XLEN-1:0]  new_imm;
    logic             new_ill;

    logic             out_valid_q;
    logic [XLEN-1:0]  out_imm_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             out_ill_q;

    logic             skid_full_q;
    logic [XLEN-1:0]  skid_imm_q;
    logic [TAG_W-1:0] skid_tag_q;
    logic             skid_ill_q;

    logic             fire_in;
    logic             fire_out;

    imm_ext_core #(.XLEN(XLEN)) u_core (
        .instr   (bus.instr),
        .ext_op  (bus.ext_op),
        .imm     (new_imm),
        .illegal (new_ill)
    );

    // in_ready depends only on the skid flop, so out_ready never reaches it combinationally.
    assign bus.in_ready = ~skid_full_q;
    assign fire_in      = bus.in_valid & ~skid_full_q;
    assign fire_out     = out_valid_q & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_imm_q   <= '0;
            out_tag_q   <= '0;
            out_ill_q   <= 1'b0;
            skid_full_q <= 1'b0;
            skid_imm_q  <= '0;
            skid_tag_q  <= '0;
            skid_ill_q  <= 1'b0;
        end else if (fire_out) begin
            if (skid_full_q) begin
                // in_ready was low, so nothing new arrives while the skid entry drains.
                out_imm_q   <= skid_imm_q;
                out_tag_q   <= skid_tag_q;
                out_ill_q   <= skid_ill_q;
                skid_full_q <= 1'b0;
            end else if (fire_in) begin
                out_imm_q   <= new_imm;
                out_tag_q   <= bus.in_tag;
                out_ill_q   <= new_ill;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (fire_in) begin
            if (!out_valid_q) begin
                out_valid_q <= 1'b1;
                out_imm_q   <= new_imm;
                out_tag_q   <= bus.in_tag;
                out_ill_q   <= new_ill;
            end else begin
                skid_full_q <= 1'b1;
                skid_imm_q  <= new_imm;
                skid_tag_q  <= bus.in_tag;
                skid_ill_q  <= new_ill;
            end
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.immout      = out_imm_q;
    assign bus.out_tag     = out_tag_q;
    assign bus.out_illegal = out_ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances driven in lockstep, checked by a scoreboard.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

`ifdef IMM_GEN_CSR_ZIMM_EN
    localparam logic [63:0] ZIMM_EXP = 64'h1F;
    localparam logic        ZIMM_ILL = 1'b0;
`else
    localparam logic [63:0] ZIMM_EXP = 64'h0;
    localparam logic        ZIMM_ILL = 1'b1;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) b32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

    int n_cmp = 0;
    int n_err = 0;
    imm_result_t exp_q32[$];
    imm_result_t exp_q64[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] op, input logic [31:0] tag);
        b32.in_valid = v; b32.instr = ins; b32.ext_op = op; b32.in_tag = tag;
        b64.in_valid = v; b64.instr = ins; b64.ext_op = op; b64.in_tag = tag;
    endtask

    task automatic set_ready(input logic r);
        b32.out_ready = r;
        b64.out_ready = r;
    endtask

    task automatic expect_push(input logic [31:0] tag, input logic [63:0] e32, input logic [63:0] e64,
                               input logic ill);
        exp_q32.push_back('{imm: e32, tag: 64'(tag), illegal: ill});
        exp_q64.push_back('{imm: e64, tag: 64'(tag), illegal: ill});
    endtask

    task automatic wait_accept();
        int  n  = 0;
        bit  ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = b32.in_ready;
            @(posedge clk);
            n++;
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
        end
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [2:0] op, input logic [31:0] tag,
                        input logic [63:0] e32, input logic [63:0] e64, input logic ill);
        drive(1'b1, ins, op, tag);
        expect_push(tag, e32, e64, ill);
        wait_accept();
        drive(1'b0, 32'h0, 3'b000, 32'h0);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q32.size() != 0 || exp_q64.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("drain_left32", 64'(exp_q32.size()), 64'h0);
        check("drain_left64", 64'(exp_q64.size()), 64'h0);
    endtask

    // ---------------- scoreboard monitors ----------------
    imm_result_t got32, hold32, e32_r;
    imm_result_t got64, hold64, e64_r;
    bit          stall32 = 1'b0;
    bit          stall64 = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall32 = 1'b0;
        end else begin
            got32 = '{imm: 64'(b32.immout), tag: 64'(b32.out_tag), illegal: b32.out_illegal};
            if (stall32) begin
                check("hold32_valid", 64'(b32.out_valid), 64'h1);
                check("hold32_data", got32, hold32);
            end
            if (b32.out_valid && b32.out_ready) begin
                if (exp_q32.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_out32: got tag 0x%0h with nothing pending", b32.out_tag);
                end else begin
                    e32_r = exp_q32.pop_front();
                    check("imm32", got32.imm, e32_r.imm);
                    check("tag32", got32.tag, e32_r.tag);
                    check("ill32", 64'(got32.illegal), 64'(e32_r.illegal));
                end
            end
            stall32 = b32.out_valid && !b32.out_ready;
            hold32  = got32;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stall64 = 1'b0;
        end else begin
            got64 = '{imm: b64.immout, tag: 64'(b64.out_tag), illegal: b64.out_illegal};
            if (stall64) begin
                check("hold64_valid", 64'(b64.out_valid), 64'h1);
                check("hold64_data", got64, hold64);
            end
            if (b64.out_valid && b64.out_ready) begin
                if (exp_q64.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_out64: got tag 0x%0h with nothing pending", b64.out_tag);
                end else begin
                    e64_r = exp_q64.pop_front();
                    check("imm64", got64.imm, e64_r.imm);
                    check("tag64", got64.tag, e64_r.tag);
                    check("ill64", 64'(got64.illegal), 64'(e64_r.illegal));
                end
            end
            stall64 = b64.out_valid && !b64.out_ready;
            hold64  = got64;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        drive(1'b0, 32'h0, 3'b000, 32'h0);
        set_ready(1'b0);

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 64'(b32.out_valid), 64'h0);
        check("rst_in_ready", 64'(b32.in_ready), 64'h1);
        check("rst_immout32", 64'(b32.immout), 64'h0);
        check("rst_immout64", b64.immout, 64'h0);
        check("rst_out_tag", 64'(b32.out_tag), 64'h0);
        check("rst_illegal", 64'(b32.out_illegal), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(b32.in_ready), 64'h1);
        @(posedge clk); #1;

        // Directed vectors, out_ready high
        set_ready(1'b1);
        send(32'hFFF00093, EXT_I, 32'h10, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        @(negedge clk);
        check("latency_one_cycle", 64'(b32.out_valid), 64'h1);
        @(posedge clk); #1;
        send(32'h7FF00093, EXT_I,        32'h11, 64'h7FF,      64'h7FF,              1'b0);
        send(32'hFE112E23, EXT_S,        32'h12, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        send(32'h80000063, EXT_B,        32'h13, 64'hFFFFF000, 64'hFFFFFFFFFFFFF000, 1'b0);
        send(32'h8000006F, EXT_J,        32'h14, 64'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0);
        send(32'h123450B7, EXT_U,        32'h15, 64'h12345000, 64'h0000000012345000, 1'b0);
        send(32'h800000B7, EXT_U,        32'h16, 64'h80000000, 64'hFFFFFFFF80000000, 1'b0);
        send(32'h03F00013, EXT_I_SHAMT,  32'h17, 64'h1F,       64'h3F,               1'b0);
        send(32'h83F01013, EXT_I_SHAMT,  32'h18, 64'h1F,       64'h3F,               1'b0);
        send(32'hFFFFFFFF, EXT_NONE,     32'h19, 64'h0,        64'h0,                1'b0);
        send(32'h800F8073, EXT_CSR_ZIMM, 32'h1A, ZIMM_EXP,     ZIMM_EXP,             ZIMM_ILL);
        drain();

        // Backpressure: tags 1,2 fill output and skid, tag 3 waits
        set_ready(1'b0);
        send(32'h00100093, EXT_I, 32'h1, 64'h1, 64'h1, 1'b0);
        send(32'h00200093, EXT_I, 32'h2, 64'h2, 64'h2, 1'b0);
        drive(1'b1, 32'h00300093, EXT_I, 32'h3);
        expect_push(32'h3, 64'h3, 64'h3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready_low", 64'(b32.in_ready), 64'h0);
            check("bp_out_tag_held", 64'(b32.out_tag), 64'h1);
        end
        @(posedge clk); #1;
        set_ready(1'b1);
        @(negedge clk);
        check("burst_tag1", 64'(b32.out_tag), 64'h1);
        @(negedge clk);
        check("burst_valid2", 64'(b32.out_valid), 64'h1);
        check("burst_tag2", 64'(b32.out_tag), 64'h2);
        check("burst_in_ready", 64'(b32.in_ready), 64'h1);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 3'b000, 32'h0);
        @(negedge clk);
        check("burst_valid3", 64'(b32.out_valid), 64'h1);
        check("burst_tag3", 64'(b32.out_tag), 64'h3);
        drain();

        // Reset with output and skid both full
        set_ready(1'b0);
        send(32'h02100093, EXT_I, 32'h21, 64'h21, 64'h21, 1'b0);
        send(32'h02200093, EXT_I, 32'h22, 64'h22, 64'h22, 1'b0);
        @(negedge clk);
        check("pre_rst_in_ready", 64'(b32.in_ready), 64'h0);
        check("pre_rst_out_valid", 64'(b32.out_valid), 64'h1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        exp_q32.delete();
        exp_q64.delete();
        #1;
        check("async_rst_out_valid", 64'(b32.out_valid), 64'h0);
        check("async_rst_in_ready", 64'(b32.in_ready), 64'h1);
        check("async_rst_immout64", b64.immout, 64'h0);
        check("async_rst_tag", 64'(b64.out_tag), 64'h0);
        set_ready(1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_stale_out32", 64'(b32.out_valid), 64'h0);
            check("no_stale_out64", 64'(b64.out_valid), 64'h0);
        end
        @(posedge clk); #1;
        send(32'hFE112E23, EXT_S, 32'h30, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, output immediate width; legal values 32 or 64.
REQ-002 SHALL have parameter TAG_W, default 32, width of the sideband tag (e.g. PC) carried with each transaction.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream transaction valid.
REQ-006 SHALL have port in_ready  output  1  block can accept this cycle.
REQ-007 SHALL have port instr  input  32  raw instruction word.
REQ-008 SHALL have port ext_op  input  3  immediate type select.
REQ-009 SHALL have port in_tag  input  TAG_W  sideband tag.
REQ-010 SHALL have port out_valid  output  1  immout valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts.
REQ-012 SHALL have port immout  output  XLEN  extended immediate.
REQ-013 SHALL have port out_tag  output  TAG_W  tag of the transaction on immout.
REQ-014 SHALL have port out_illegal  output  1  ext_op was unsupported; immout is 0.

Function
REQ-015 ext_op encodings SHALL be: 000 NONE, 001 S, 010 I, 011 I_SHAMT, 100 B, 101 U, 110 J, 111 CSR_ZIMM.
REQ-016 Field extraction SHALL be: I instr[31:20]; S {instr[31:25],instr[11:7]}; B {instr[31],instr[7],instr[30:25],instr[11:8],0}; U {instr[31:12],12'b0}; J {instr[31],instr[19:12],instr[20],instr[30:21],0}.
REQ-017 I, S, B, U and J results SHALL be sign-extended from instr[31] to XLEN (U included, for XLEN=64).
REQ-018 I_SHAMT SHALL zero-extend instr[24:20] when XLEN=32 and instr[25:20] when XLEN=64.
REQ-019 NONE SHALL yield immout 0 with out_illegal 0.
REQ-020 A transfer SHALL occur on in_valid&&in_ready; out handshake on out_valid&&out_ready.
REQ-021 Latency accept-to-out_valid SHALL be exactly 1 cycle when unstalled; sustained throughput 1 per cycle.
REQ-022 Output SHALL be registered: a 1-entry output register plus a 1-entry skid register.
REQ-023 in_ready SHALL equal NOT skid_full and SHALL be driven from registers only, with no combinational path from out_ready.
REQ-024 When out_valid&&!out_ready and a transfer occurs, the new result SHALL go to the skid register; on the next out handshake the skid entry SHALL move to the output register.
REQ-025 Ordering SHALL be strict FIFO; no transaction dropped or duplicated.
REQ-026 immout, out_tag and out_illegal SHALL hold stable while out_valid&&!out_ready.
REQ-027 Simultaneous out handshake and input transfer with skid empty SHALL load the output register directly from the input.

Reset
REQ-028 rst_n low SHALL asynchronously clear out_valid, skid_full, immout, out_tag and out_illegal to 0; in_ready SHALL read 1 while rst_n is low and after release.
REQ-029 Reset mid-transfer SHALL discard all in-flight entries; no output after release without a new input.

Configuration
REQ-030 Macro IMM_GEN_CSR_ZIMM_EN defined: CSR_ZIMM SHALL zero-extend instr[19:15] with out_illegal 0.
REQ-031 Macro IMM_GEN_CSR_ZIMM_EN undefined: CSR_ZIMM SHALL yield immout 0 with out_illegal 1.

Structure
REQ-032 Package imm_gen_pkg SHALL hold the ext_op encodings, a result struct (imm, tag, illegal) and XLEN legality constants.
REQ-033 Extraction/extension SHALL be a combinational sub-module imm_ext_core; the handshake/skid logic SHALL stay in imm_gen_pipe.

Verification
REQ-034 I type, XLEN=32: instr 0xFFF00093, ext_op 010 -> immout 0xFFFFFFFF one cycle later.
REQ-035 S type: instr 0xFE112E23, ext_op 001 -> 0xFFFFFFFC; B type: instr 0x80000063, ext_op 100 -> 0xFFFFF000; J type: instr 0x8000006F, ext_op 110 -> 0xFFF00000.
REQ-036 U type, XLEN=64: instr 0x123450B7, ext_op 101 -> 0x0000000012345000; I_SHAMT with instr[25:20]=0x3F -> 0x3F.
REQ-037 Backpressure: out_ready=0, offer tags 1,2,3 -> in_ready falls after tag 2 is accepted and tag 3 is held; raise out_ready -> tags 1,2,3 emerge in order on consecutive cycles.
REQ-038 CSR_ZIMM: instr[19:15]=0x1F, ext_op 111 -> 0x1F with out_illegal 0 when the macro is defined; 0 with out_illegal 1 when undefined.
REQ-039 Reset mid-operation: rst_n low while out_valid=1 and skid full -> out_valid 0 and in_ready 1 immediately, with no stale output after release.
